pipe_hazard_ctrl: RTL and testbench

- Sequences the IF/ID and ID/EXMEM pipeline registers of the processor.
- Generates register enables and the PC enable.
- Generates flush (IF/ID) and bubble-insert (ID/EXMEM, which drives NOP/passb values) controls.
- Generates operand-forwarding selects.
- Handles load-use hazards, taken-branch flushes and data-memory wait handshakes. Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences IF/ID and ID/EXMEM enables, flush and
// bubble controls, operand forwarding selects, and memory-wait handling with a
// sticky timeout flag and saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       id_RA,
  input  logic [3:0]       id_RB,
  input  logic             id_use_RA,
  input  logic             id_use_RB,
  input  logic [3:0]       ex_WC,
  input  logic [2:0]       ex_W_RF,
  input  logic [1:0]       ex_S_MXRB,
  input  logic             ex_W_DM,
  input  logic [3:0]       wb_WC,
  input  logic [2:0]       wb_W_RF,
  input  logic             br_taken,
  input  logic             dm_ready,
  output logic             en_PC,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             flush_IFID,
  output logic             bubble_IDEX,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_FLUSH} state_t;

  localparam logic [15:0] TIMEOUT   = 16'(MEM_TIMEOUT);
  localparam logic [2:0]  FLUSH_REM = 3'(FLUSH_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_fcnt, w_fcnt_nxt;
  logic [15:0]      r_wcnt, w_wcnt_inc;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_is_load, w_mem_op, w_mem_busy, w_load_use, w_stall_mem, w_br_start;

  assign w_is_load  = (ex_S_MXRB == 2'b01) && (ex_W_RF != 3'd0);
  assign w_mem_op   = w_is_load || ex_W_DM;
  assign w_mem_busy = w_mem_op && !dm_ready;
  assign w_load_use = w_is_load && ((id_use_RA && (id_RA == ex_WC)) ||
                                    (id_use_RB && (id_RB == ex_WC)));

  // Once in MEM_WAIT only dm_ready releases the freeze; elsewhere a busy
  // memory op freezes the pipe (including the unexpected case inside FLUSH).
  assign w_stall_mem = (r_state == S_MEM_WAIT) ? !dm_ready : w_mem_busy;

  // Wait counter saturates at the timeout so it can never wrap back to 0.
  assign w_wcnt_inc = (r_wcnt >= TIMEOUT) ? r_wcnt : r_wcnt + 16'd1;

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Next-state and pipeline control; reset forces everything to NOP/hold.
  always_comb begin
    en_PC       = 1'b1;
    en_IFID     = 1'b1;
    en_IDEX     = 1'b1;
    flush_IFID  = 1'b0;
    bubble_IDEX = 1'b0;
    w_br_start  = 1'b0;
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (RESET) begin
      en_PC       = 1'b0;
      en_IFID     = 1'b0;
      en_IDEX     = 1'b0;
      flush_IFID  = 1'b1;
      bubble_IDEX = 1'b1;
      w_state_nxt = S_RUN;
    end else if (w_stall_mem) begin
      en_PC   = 1'b0;
      en_IFID = 1'b0;
      en_IDEX = 1'b0;
      if (r_state == S_RUN) w_state_nxt = S_MEM_WAIT;
    end else if (r_state == S_FLUSH) begin
      // Squashed instructions: branch and load-use are ignored here.
      flush_IFID  = 1'b1;
      bubble_IDEX = 1'b1;
      w_fcnt_nxt  = r_fcnt - 3'd1;
      if (r_fcnt <= 3'd1) w_state_nxt = S_RUN;
    end else begin
      // RUN, or the dm_ready cycle of MEM_WAIT.
      w_state_nxt = S_RUN;
      if (br_taken) begin
        flush_IFID  = 1'b1;
        bubble_IDEX = 1'b1;
        w_br_start  = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FLUSH_REM;
        end
      end else if (w_load_use) begin
        // One bubble is enough: the load result forwards from WB next cycle.
        en_PC       = 1'b0;
        en_IFID     = 1'b0;
        bubble_IDEX = 1'b1;
      end
    end
  end

  // State, flush/wait counters, sticky error and performance counters.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= S_RUN;
      r_fcnt      <= 3'd0;
      r_wcnt      <= 16'd0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_wcnt  <= w_stall_mem ? w_wcnt_inc : 16'd0;
      if (w_stall_mem && (w_wcnt_inc >= TIMEOUT)) r_mem_err <= 1'b1;
      if (!en_PC && (r_stall_cnt != {CNT_W{1'b1}})) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br_start && (r_flush_cnt != {CNT_W{1'b1}})) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Operand forwarding; EX/MEM wins over WB, loads are not forwardable from EX/MEM.
  always_comb begin
    fwd_A = 2'b00;
    fwd_B = 2'b00;
    if ((ex_W_RF != 3'd0) && !w_is_load && (ex_WC == id_RA)) fwd_A = 2'b01;
    else if ((wb_W_RF != 3'd0) && (wb_WC == id_RA))          fwd_A = 2'b10;
    if ((ex_W_RF != 3'd0) && !w_is_load && (ex_WC == id_RB)) fwd_B = 2'b01;
    else if ((wb_W_RF != 3'd0) && (wb_WC == id_RB))          fwd_B = 2'b10;
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=3, CNT_W=4).
module tb_pipe_hazard_ctrl;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [3:0]    id_RA, id_RB, ex_WC, wb_WC;
  logic          id_use_RA, id_use_RB, ex_W_DM, br_taken, dm_ready;
  logic [2:0]    ex_W_RF, wb_W_RF;
  logic [1:0]    ex_S_MXRB;
  logic          en_PC, en_IFID, en_IDEX, flush_IFID, bubble_IDEX, mem_err;
  logic [1:0]    fwd_A, fwd_B;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [4:0]    ctl;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(3), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_RA(id_RA), .id_RB(id_RB), .id_use_RA(id_use_RA), .id_use_RB(id_use_RB),
    .ex_WC(ex_WC), .ex_W_RF(ex_W_RF), .ex_S_MXRB(ex_S_MXRB), .ex_W_DM(ex_W_DM),
    .wb_WC(wb_WC), .wb_W_RF(wb_W_RF), .br_taken(br_taken), .dm_ready(dm_ready),
    .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX),
    .flush_IFID(flush_IFID), .bubble_IDEX(bubble_IDEX),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  // {en_PC, en_IFID, en_IDEX, flush_IFID, bubble_IDEX}
  assign ctl = {en_PC, en_IFID, en_IDEX, flush_IFID, bubble_IDEX};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic clr_in;
    id_RA = 4'd0; id_RB = 4'd0; id_use_RA = 1'b0; id_use_RB = 1'b0;
    ex_WC = 4'd0; ex_W_RF = 3'd0; ex_S_MXRB = 2'b00; ex_W_DM = 1'b0;
    wb_WC = 4'd0; wb_W_RF = 3'd0; br_taken = 1'b0; dm_ready = 1'b1;
  endtask

  task automatic do_reset;
    clr_in();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
  endtask

  initial begin
    clr_in();
    RESET = 1'b1;
    tick();
    tick();
    chk("rst_ctl", 32'(ctl), 32'b00011);
    chk("rst_stall", 32'(stall_cnt), 0);
    chk("rst_flush", 32'(flush_cnt), 0);
    chk("rst_err", 32'(mem_err), 0);
    RESET = 1'b0;
    #1;
    chk("idle_ctl", 32'(ctl), 32'b11100);

    // Forwarding patterns
    ex_W_RF = 3'd1; ex_WC = 4'd3; id_RA = 4'd3; id_RB = 4'd7;
    wb_W_RF = 3'd2; wb_WC = 4'd7;
    #1;
    chk("fwdA_ex", 32'(fwd_A), 2'b01);
    chk("fwdB_wb", 32'(fwd_B), 2'b10);
    id_RB = 4'd3; wb_WC = 4'd3;
    #1;
    chk("fwdB_both", 32'(fwd_B), 2'b01);
    ex_S_MXRB = 2'b01;
    #1;
    chk("fwdA_load_wb", 32'(fwd_A), 2'b10);
    clr_in();
    ex_W_RF = 3'd4; wb_W_RF = 3'd1;
    #1;
    chk("fwdA_r0", 32'(fwd_A), 2'b01);
    clr_in();
    #1;
    chk("fwd_none", 32'({fwd_A, fwd_B}), 4'b0000);
    tick();

    // Load-use: one stall cycle with bubble, then WB forwarding
    ex_S_MXRB = 2'b01; ex_W_RF = 3'd1; ex_WC = 4'd5; id_RA = 4'd5; id_use_RA = 1'b1;
    #1;
    chk("lu_ctl", 32'(ctl), 32'b00101);
    chk("lu_fwdA", 32'(fwd_A), 2'b00);
    tick();
    chk("lu_stall", 32'(stall_cnt), 1);
    ex_S_MXRB = 2'b00; ex_W_RF = 3'd0; ex_WC = 4'd0; wb_WC = 4'd5; wb_W_RF = 3'd1;
    #1;
    chk("lu_next_ctl", 32'(ctl), 32'b11100);
    chk("lu_next_fwdA", 32'(fwd_A), 2'b10);
    clr_in();
    ex_S_MXRB = 2'b01; ex_W_RF = 3'd1; ex_WC = 4'd5; id_RA = 4'd5; id_use_RA = 1'b0;
    #1;
    chk("lu_nouse_ctl", 32'(ctl), 32'b11100);
    tick();
    chk("lu_nouse_stall", 32'(stall_cnt), 1);

    // Branch: 2 flush cycles, branch/load-use ignored while flushing
    do_reset();
    br_taken = 1'b1;
    #1;
    chk("br_c1", 32'(ctl), 32'b11111);
    tick();
    br_taken = 1'b0;
    #1;
    chk("br_c2", 32'(ctl), 32'b11111);
    chk("br_fcnt", 32'(flush_cnt), 1);
    tick();
    chk("br_c3", 32'(ctl), 32'b11100);
    br_taken = 1'b1;
    tick();
    ex_S_MXRB = 2'b01; ex_W_RF = 3'd1; ex_WC = 4'd5; id_RA = 4'd5; id_use_RA = 1'b1;
    #1;
    chk("br_flush_ign", 32'(ctl), 32'b11111);
    tick();
    clr_in();
    #1;
    chk("br_back_run", 32'(ctl), 32'b11100);
    chk("br_fcnt2", 32'(flush_cnt), 2);
    chk("br_stall0", 32'(stall_cnt), 0);

    // Memory wait: 4 cycles frozen, timeout 3 sets the sticky error
    do_reset();
    ex_W_DM = 1'b1; dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_ctl", 32'(ctl), 32'b00000);
      tick();
      chk("mw_err", 32'(mem_err), (i >= 2) ? 1 : 0);
    end
    chk("mw_stall", 32'(stall_cnt), 4);
    dm_ready = 1'b1;
    #1;
    chk("mw_ready_ctl", 32'(ctl), 32'b11111 & 32'b11100);
    tick();
    ex_W_DM = 1'b0;
    #1;
    chk("mw_after_ctl", 32'(ctl), 32'b11100);
    chk("mw_after_stall", 32'(stall_cnt), 4);
    chk("mw_err_sticky", 32'(mem_err), 1);
    do_reset();
    chk("mw_err_clr", 32'(mem_err), 0);

    // Long wait: stall counter saturates at all-ones
    ex_W_DM = 1'b1; dm_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 32'(stall_cnt), 15);
    chk("sat_err", 32'(mem_err), 1);
    dm_ready = 1'b1;
    #1;
    chk("sat_release", 32'(ctl), 32'b11100);
    tick();
    chk("sat_hold", 32'(stall_cnt), 15);

    // Priority: freeze, then flush (not stall) on the ready cycle
    do_reset();
    ex_S_MXRB = 2'b01; ex_W_RF = 3'd1; ex_WC = 4'd5; id_RA = 4'd5; id_use_RA = 1'b1;
    br_taken = 1'b1; dm_ready = 1'b0;
    #1;
    chk("pri_c1", 32'(ctl), 32'b00000);
    tick();
    chk("pri_c2", 32'(ctl), 32'b00000);
    tick();
    dm_ready = 1'b1;
    #1;
    chk("pri_ready", 32'(ctl), 32'b11111);
    tick();
    clr_in();
    #1;
    chk("pri_flush", 32'(ctl), 32'b11111);
    chk("pri_fcnt", 32'(flush_cnt), 1);
    chk("pri_stall", 32'(stall_cnt), 2);
    tick();
    chk("pri_run", 32'(ctl), 32'b11100);

    // Asynchronous reset in the middle of FLUSH
    br_taken = 1'b1;
    tick();
    br_taken = 1'b0;
    #1;
    chk("rf_in_flush", 32'(ctl), 32'b11111);
    RESET = 1'b1;
    #1;
    chk("rf_async_ctl", 32'(ctl), 32'b00011);
    chk("rf_async_fcnt", 32'(flush_cnt), 0);
    chk("rf_async_stall", 32'(stall_cnt), 0);
    tick();
    chk("rf_hold_ctl", 32'(ctl), 32'b00011);
    RESET = 1'b0;
    #1;
    chk("rf_rel_ctl", 32'(ctl), 32'b11100);
    tick();
    chk("rf_run_ctl", 32'(ctl), 32'b11100);
    chk("rf_run_cnts", 32'({flush_cnt, stall_cnt, 3'b000, mem_err}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
